// File: rtl/router_reg_if.sv
// Source-side byte stream and FIFO-side write data/status for router_reg.
// master drives the source byte stream and FIFO full flag; slave is the register block.
interface router_reg_if;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;

    modport master (
        output pkt_valid, data_in, fifo_full,
        input  dout, parity_done, low_pkt_valid, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        output dout, parity_done, low_pkt_valid, err
    );
endinterface

// File: rtl/router_reg.sv
// Router datapath registers: header/full-hold capture, running parity and parity-error flag.
// Optional ROUTER_REG_ERR_CNT_EN adds a saturating 8-bit bad-packet counter output err_cnt.
module router_reg (
    input  logic         clock,
    input  logic         resetn,
    router_reg_if.slave  bus,
    input  logic         detect_add,
    input  logic         lfd_state,
    input  logic         ld_state,
    input  logic         full_state,
    input  logic         laf_state,
    input  logic         rst_int_reg
`ifdef ROUTER_REG_ERR_CNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);

    logic [7:0] hdr_reg;
    logic [7:0] full_hold_reg;
    logic [7:0] int_parity_reg;
    logic [7:0] pkt_parity_reg;
    logic [7:0] dout_reg;
    logic       parity_done_reg;
    logic       low_pkt_valid_reg;
    logic       err_reg;
    logic       parity_mismatch;
    logic       hdr_addr_ok;

    // full_state carries no datapath action here; the stalled byte is handled via fifo_full in ld_state
    logic       unused_full_state;
    assign unused_full_state = full_state;

    assign parity_mismatch = (int_parity_reg != pkt_parity_reg);
    assign hdr_addr_ok     = (bus.data_in[1:0] != 2'b11);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            hdr_reg       <= 8'h00;
            full_hold_reg <= 8'h00;
            dout_reg      <= 8'h00;
        end else begin
            if (detect_add && bus.pkt_valid && hdr_addr_ok)
                hdr_reg <= bus.data_in;

            if (ld_state && bus.fifo_full)
                full_hold_reg <= bus.data_in;

            if (lfd_state)
                dout_reg <= hdr_reg;
            else if (ld_state && !bus.fifo_full)
                dout_reg <= bus.data_in;
            else if (laf_state)
                dout_reg <= full_hold_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            int_parity_reg <= 8'h00;
            pkt_parity_reg <= 8'h00;
        end else begin
            if (detect_add)
                int_parity_reg <= 8'h00;
            else if (lfd_state)
                int_parity_reg <= int_parity_reg ^ hdr_reg;
            else if (ld_state && bus.pkt_valid)
                int_parity_reg <= int_parity_reg ^ bus.data_in;

            if (detect_add)
                pkt_parity_reg <= 8'h00;
            else if (ld_state && !bus.pkt_valid)
                pkt_parity_reg <= bus.data_in;
        end
    end

    // err samples the pre-clear parities even when detect_add lands on the same edge
    always_ff @(posedge clock) begin
        if (!resetn) begin
            parity_done_reg   <= 1'b0;
            low_pkt_valid_reg <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            if (detect_add)
                parity_done_reg <= 1'b0;
            else if ((ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                     (laf_state && low_pkt_valid_reg && !parity_done_reg))
                parity_done_reg <= 1'b1;

            if (rst_int_reg)
                low_pkt_valid_reg <= 1'b0;
            else if (ld_state && !bus.pkt_valid)
                low_pkt_valid_reg <= 1'b1;

            if (parity_done_reg)
                err_reg <= parity_mismatch;
        end
    end

`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    // parity_done stays high until detect_add, so this edge is seen once per packet
    always_ff @(posedge clock) begin
        if (!resetn)
            err_cnt_reg <= 8'h00;
        else if (parity_done_reg && detect_add && parity_mismatch && (err_cnt_reg != 8'hFF))
            err_cnt_reg <= err_cnt_reg + 8'h01;
    end

    assign err_cnt = err_cnt_reg;
`endif

    assign bus.dout          = dout_reg;
    assign bus.parity_done   = parity_done_reg;
    assign bus.low_pkt_valid = low_pkt_valid_reg;
    assign bus.err           = err_reg;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: packet-level reference model checked every cycle,
// plus hand-computed literal checks on key points of each scenario.
module tb_router_reg;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetn;
    logic detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
    router_reg_if bus();
`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    router_reg dut (
        .clock       (clock),
        .resetn      (resetn),
        .bus         (bus),
        .detect_add  (detect_add),
        .lfd_state   (lfd_state),
        .ld_state    (ld_state),
        .full_state  (full_state),
        .laf_state   (laf_state),
        .rst_int_reg (rst_int_reg)
`ifdef ROUTER_REG_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    // Reference model: parity is the XOR of every byte accepted into the current packet
    logic [7:0] par_bytes[$];
    logic [7:0] m_hdr, m_hold, m_pkt_par, m_dout, m_cnt;
    logic       m_done, m_low, m_err;

    function automatic logic [7:0] xor_all();
        logic [7:0] acc;
        acc = 8'h00;
        foreach (par_bytes[i]) acc = acc ^ par_bytes[i];
        return acc;
    endfunction

    task automatic model_step();
        logic [7:0] running;
        logic       bad;
        logic [7:0] n_dout;
        running = xor_all();
        bad     = (running != m_pkt_par);
        if (!resetn) begin
            par_bytes.delete();
            m_hdr = 0; m_hold = 0; m_pkt_par = 0; m_dout = 0; m_cnt = 0;
            m_done = 0; m_low = 0; m_err = 0;
        end else begin
            if (m_done && detect_add && bad && m_cnt != 8'hFF) m_cnt = m_cnt + 1;
            if (m_done) m_err = bad;
            n_dout = m_dout;
            if (lfd_state) n_dout = m_hdr;
            else if (ld_state && !bus.fifo_full) n_dout = bus.data_in;
            else if (laf_state) n_dout = m_hold;
            m_dout = n_dout;
            if (detect_add) m_done = 0;
            else if ((ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                     (laf_state && m_low && !m_done)) m_done = 1;
            if (rst_int_reg) m_low = 0;
            else if (ld_state && !bus.pkt_valid) m_low = 1;
            if (ld_state && bus.fifo_full) m_hold = bus.data_in;
            if (detect_add) m_pkt_par = 0;
            else if (ld_state && !bus.pkt_valid) m_pkt_par = bus.data_in;
            if (detect_add) par_bytes.delete();
            else if (lfd_state) par_bytes.push_back(m_hdr);
            else if (ld_state && bus.pkt_valid) par_bytes.push_back(bus.data_in);
            if (detect_add && bus.pkt_valid && bus.data_in[1:0] != 2'b11) m_hdr = bus.data_in;
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check8("dout", bus.dout, m_dout);
            check8("parity_done", {7'b0, bus.parity_done}, {7'b0, m_done});
            check8("low_pkt_valid", {7'b0, bus.low_pkt_valid}, {7'b0, m_low});
            check8("err", {7'b0, bus.err}, {7'b0, m_err});
`ifdef ROUTER_REG_ERR_CNT_EN
            check8("err_cnt", err_cnt, m_cnt);
`endif
        end
    end

    // One clock with the given decode/data; returns 1 time unit after the edge.
    task automatic go(input logic rn, input logic da, input logic lfd, input logic ld,
                      input logic laf, input logic rir, input logic pv,
                      input logic [7:0] d, input logic full);
        resetn = rn; detect_add = da; lfd_state = lfd; ld_state = ld;
        laf_state = laf; rst_int_reg = rir; full_state = 1'b0;
        bus.pkt_valid = pv; bus.data_in = d; bus.fifo_full = full;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic t_da(input logic [7:0] h, input logic pv); go(1,1,0,0,0,0,pv,h,0); endtask
    task automatic t_lfd();  go(1,0,1,0,0,0,1,8'h00,0); endtask
    task automatic t_ld(input logic [7:0] d, input logic pv, input logic full); go(1,0,0,1,0,0,pv,d,full); endtask
    task automatic t_laf();  go(1,0,0,0,1,0,1,8'h00,0); endtask
    task automatic t_rint(); go(1,0,0,0,0,1,1,8'h00,0); endtask
    task automatic t_idle(); go(1,0,0,0,0,0,1,8'h00,0); endtask

    initial begin
        go(0,0,0,0,0,0,0,8'hA5,0);
        go(0,0,0,0,0,0,0,8'hA5,0);
        chk_en = 1'b1;
        check8("rst_dout", bus.dout, 8'h00);
        check8("rst_err", {7'b0, bus.err}, 8'h00);
        check8("rst_done", {7'b0, bus.parity_done}, 8'h00);
        $display("reset applied");

        // good packet
        t_da(8'h0D, 1); t_lfd();  check8("good_hdr", bus.dout, 8'h0D);
        t_ld(8'h11, 1, 0);        check8("good_b1", bus.dout, 8'h11);
        t_ld(8'h22, 1, 0);        check8("good_b2", bus.dout, 8'h22);
        t_ld(8'h33, 1, 0);        check8("good_b3", bus.dout, 8'h33);
        t_ld(8'h0D, 0, 0);        check8("good_par", bus.dout, 8'h0D);
        check8("good_done", {7'b0, bus.parity_done}, 8'h01);
        t_idle();                 check8("good_err", {7'b0, bus.err}, 8'h00);
        $display("good packet 0D/11/22/33/0D");

        // bad parity
        t_da(8'h0D, 1); t_lfd();
        t_ld(8'h11, 1, 0); t_ld(8'h22, 1, 0); t_ld(8'h33, 1, 0); t_ld(8'h0C, 0, 0);
        t_idle();                 check8("bad_err", {7'b0, bus.err}, 8'h01);
        $display("bad parity packet");

        // full stall
        t_da(8'h0D, 1);
`ifdef ROUTER_REG_ERR_CNT_EN
        check8("cnt_first", err_cnt, 8'h01);
`endif
        check8("stall_done_clr", {7'b0, bus.parity_done}, 8'h00);
        t_lfd(); t_ld(8'h11, 1, 0);
        t_ld(8'h22, 1, 1);        check8("stall_hold", bus.dout, 8'h11);
        t_laf();                  check8("stall_laf", bus.dout, 8'h22);
        t_ld(8'h33, 1, 0); t_ld(8'h0D, 0, 0);
        t_idle();                 check8("stall_err", {7'b0, bus.err}, 8'h00);
        $display("full stall packet");

        // low valid while full
        t_da(8'h0D, 1); t_lfd();
        t_ld(8'h11, 1, 0); t_ld(8'h22, 1, 0); t_ld(8'h33, 1, 0);
        t_ld(8'h0D, 0, 1);
        check8("lowv_set", {7'b0, bus.low_pkt_valid}, 8'h01);
        check8("lowv_dout", bus.dout, 8'h33);
        t_laf();
        check8("lowv_done", {7'b0, bus.parity_done}, 8'h01);
        check8("lowv_laf", bus.dout, 8'h0D);
        t_rint();
        check8("lowv_clr", {7'b0, bus.low_pkt_valid}, 8'h00);
        check8("lowv_err", {7'b0, bus.err}, 8'h00);
        $display("low valid after full");

        // invalid / non-valid headers must not load
        t_da(8'h26, 1); t_lfd();  check8("hdr_26", bus.dout, 8'h26);
        t_da(8'h07, 1); t_lfd();  check8("hdr_inval", bus.dout, 8'h26);
        t_da(8'h15, 0); t_lfd();  check8("hdr_nopv", bus.dout, 8'h26);
        $display("invalid address header");

        // detect_add on the same edge as parity_done
        t_da(8'h0D, 1); t_lfd();
        t_ld(8'h11, 1, 0); t_ld(8'h22, 1, 0); t_ld(8'h33, 1, 0); t_ld(8'h0C, 0, 0);
        t_da(8'h0D, 1);
        check8("simul_err", {7'b0, bus.err}, 8'h01);
        check8("simul_done", {7'b0, bus.parity_done}, 8'h00);
        $display("detect_add with parity_done");

        // reset mid-packet
        t_lfd(); t_ld(8'h11, 1, 0); t_ld(8'h5A, 0, 1);
        go(0,0,0,1,0,0,1,8'h22,0);
        check8("mid_dout", bus.dout, 8'h00);
        check8("mid_low", {7'b0, bus.low_pkt_valid}, 8'h00);
        check8("mid_err", {7'b0, bus.err}, 8'h00);
`ifdef ROUTER_REG_ERR_CNT_EN
        check8("mid_cnt", err_cnt, 8'h00);
`endif
        $display("reset mid-packet");

        // many bad packets: header 0D, parity byte 00
        for (int i = 0; i < 260; i++) begin
            t_da(8'h0D, 1); t_lfd(); t_ld(8'h00, 0, 0);
        end
        t_da(8'h0D, 1);
`ifdef ROUTER_REG_ERR_CNT_EN
        check8("cnt_sat", err_cnt, 8'hFF);
`endif
        check8("sat_err", {7'b0, bus.err}, 8'h01);
        $display("260 bad packets");

        t_idle();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/router_reg.md
ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 clock  input  1  rising-edge clock for all state.
REQ-002 resetn  input  1  reset; synchronous, active-low.
REQ-003 pkt_valid  input  1  source byte valid; low marks the parity byte.
REQ-004 data_in  input  8  source byte; header format {len[5:0], addr[1:0]}.
REQ-005 fifo_full  input  1  full flag of the FIFO selected by the current packet.
REQ-006 detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg  input  1 each  one-hot state decodes from router_fsm.
REQ-007 dout  output  8  registered byte to FIFO write port.
REQ-008 parity_done  output  1  parity byte captured for the current packet.
REQ-009 low_pkt_valid  output  1  pkt_valid fell while in LOAD_DATA.
REQ-010 err  output  1  last completed packet had a parity mismatch.

Function
REQ-011 All outputs and internal registers SHALL be updated only on the rising edge of clock; no combinational input-to-output path.
REQ-012 hdr_reg(8) SHALL load data_in when detect_add && pkt_valid && data_in[1:0] != 2'b11; otherwise it holds.
REQ-013 dout priority: lfd_state -> hdr_reg; else ld_state && !fifo_full -> data_in; else laf_state -> full_hold; else hold.
REQ-014 full_hold(8) SHALL load data_in when ld_state && fifo_full; otherwise it holds.
REQ-015 int_parity(8) priority: detect_add -> 0; lfd_state -> int_parity ^ hdr_reg; ld_state && pkt_valid -> int_parity ^ data_in; else hold.
REQ-016 pkt_parity(8) SHALL load data_in when ld_state && !pkt_valid; it SHALL be cleared on detect_add.
REQ-017 parity_done priority: detect_add -> 0; (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_pkt_valid && !parity_done) -> 1; else hold.
REQ-018 low_pkt_valid priority: rst_int_reg -> 0; ld_state && !pkt_valid -> 1; else hold.
REQ-019 err SHALL be loaded with (int_parity != pkt_parity) on every edge where parity_done == 1; otherwise it holds. It therefore settles one cycle after parity_done rises and stays valid until the next packet's compare.
REQ-020 Full boundary: a byte arriving in ld_state with fifo_full SHALL NOT change dout. It SHALL be captured in full_hold, included in int_parity if pkt_valid, and driven on dout in the laf_state cycle.
REQ-021 Simultaneous detect_add and parity_done==1: err compare SHALL use the pre-clear int_parity/pkt_parity values, then both clear.
REQ-022 Decode inputs are trusted one-hot. Behaviour with more than one asserted is defined solely by the priorities above.

Reset
REQ-023 resetn==0 at a rising edge SHALL set dout, hdr_reg, full_hold, int_parity, pkt_parity to 8'h00 and parity_done, low_pkt_valid, err to 0, overriding all other conditions, including mid-packet.

Configuration
REQ-024 Macro ROUTER_REG_ERR_CNT_EN defined: add output err_cnt (8 bits). It SHALL increment by 1, saturating at 8'hFF, on each edge where parity_done==1 && detect_add && int_parity != pkt_parity. This counts exactly once per bad packet. It is reset to 0 by resetn only.
REQ-025 Macro undefined: no err_cnt port or logic. All other behaviour is identical.

Verification
REQ-026 Good packet: header 0x0D, payload 0x11,0x22,0x33, parity 0x0D, no fifo_full -> dout sequence 0x0D,0x11,0x22,0x33,0x0D; parity_done=1; err=0 one cycle later.
REQ-027 Bad parity: same packet with parity byte 0x0C -> err=1 after parity_done. With ROUTER_REG_ERR_CNT_EN, err_cnt goes 0->1 at the next detect_add edge.
REQ-028 Full stall: fifo_full=1 during ld_state with data_in=0x22 -> dout unchanged, full_hold=0x22. Next laf_state -> dout=0x22, and int_parity includes 0x22.
REQ-029 Low-valid after full: pkt_valid falls on parity byte 0x0D while fifo_full -> low_pkt_valid=1 and pkt_parity=0x0D. In laf_state, parity_done rises. rst_int_reg then clears low_pkt_valid.
REQ-030 Invalid address: detect_add && pkt_valid with data_in=0x07 -> hdr_reg keeps its prior value.
REQ-031 Reset mid-packet: resetn=0 during ld_state -> next edge all outputs 0. With the macro defined, err_cnt=0 and saturation holds at 0xFF after 256+ bad packets.
